// File: rtl/fifo_pop_ctrl_pkg.sv
// Shared definitions for the FIFO pop controller: widths, FSM encoding, occupancy helper.
package fifo_pop_ctrl_pkg;

  localparam int unsigned DEF_DATA_BITS = 10;
  localparam int unsigned WORD_CNT_BITS = 16;
  localparam int unsigned OCC_BITS      = 2;
  localparam int unsigned PEND_BITS     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // Words that will occupy the buffer next cycle; 3 bits so the subtraction never wraps.
  function automatic logic [PEND_BITS-1:0] pending(input logic [OCC_BITS-1:0] occ,
                                                   input logic                infl,
                                                   input logic                pop);
    return PEND_BITS'(occ) + PEND_BITS'(infl) - PEND_BITS'(pop);
  endfunction

endpackage

// File: rtl/fifo_pop_ctrl_skid_buf.sv
// Two-entry skid buffer with head/tail pointers; head entry is presented on o_data.
module fifo_pop_ctrl_skid_buf
  import fifo_pop_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_pop,
  output logic [DATA_BITS-1:0] o_data,
  output logic [OCC_BITS-1:0]  o_occ
);

  logic [DATA_BITS-1:0] r_mem [2];
  logic                 r_head;
  logic                 r_tail;
  logic [OCC_BITS-1:0]  r_occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_data;
        r_tail        <= ~r_tail;
      end
      if (i_pop) begin
        r_head <= ~r_head;
      end
      r_occ <= r_occ + OCC_BITS'(i_push) - OCC_BITS'(i_pop);
    end
  end

  assign o_data = r_mem[r_head];
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_pop_ctrl.sv
// Drains a synchronous FIFO into a valid/ready consumer through a 2-entry skid buffer.
// Optional delivered-word counter when FIFO_POP_CNT_EN is defined.
module fifo_pop_ctrl
  import fifo_pop_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_BITS-1:0]     fifo_data_out,
  input  logic                     fifo_empty,
  input  logic                     fifo_error,
  output logic                     fifo_read,
  output logic [DATA_BITS-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef FIFO_POP_CNT_EN
  output logic [WORD_CNT_BITS-1:0] word_count,
`endif
  output logic                     error_out
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_infl;
  logic                r_error;
  logic                w_rd;
  logic                w_pop;
  logic [OCC_BITS-1:0] w_occ;

  assign out_valid = (w_occ != '0);
  assign w_pop     = out_valid & out_ready;
  assign fifo_read = w_rd;
  assign error_out = r_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Reads are only issued in RUN when the buffer is guaranteed room for the returning word.
  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_RUN;
      ST_RUN:  w_rd = ~fifo_empty & (pending(w_occ, r_infl, w_pop) < PEND_BITS'(2));
      ST_ERR:  w_state_nxt = ST_ERR;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (fifo_error) begin
      w_state_nxt = ST_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_infl  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_infl <= w_rd;
      if (fifo_error) begin
        r_error <= 1'b1;
      end
    end
  end

  fifo_pop_ctrl_skid_buf #(
    .DATA_BITS (DATA_BITS)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .i_push (r_infl),
    .i_data (fifo_data_out),
    .i_pop  (w_pop),
    .o_data (out_data),
    .o_occ  (w_occ)
  );

`ifdef FIFO_POP_CNT_EN
  logic [WORD_CNT_BITS-1:0] r_word_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word_count <= '0;
    end else if (w_pop) begin
      r_word_count <= r_word_count + WORD_CNT_BITS'(1);
    end
  end

  assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Bench for fifo_pop_ctrl: hand-derived vector table, corner sequences and a queue-based reference model.
module tb_fifo_pop_ctrl;

  localparam int unsigned DW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_empty;
  logic          fifo_error;
  logic          fifo_read;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          error_out;
`ifdef FIFO_POP_CNT_EN
  logic [15:0]   word_count;
`endif

  always #5 clk = ~clk;

  fifo_pop_ctrl #(.DATA_BITS(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_error    (fifo_error),
    .fifo_read     (fifo_read),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
`ifdef FIFO_POP_CNT_EN
    .word_count    (word_count),
`endif
    .error_out     (error_out)
  );

  typedef struct {
    bit          preload;
    bit          rst;
    bit          rdy;
    bit          err;
    bit          e_read;
    bit          e_valid;
    logic [DW-1:0] e_data;
    bit          e_err;
  } vec_t;

  vec_t tbl[$];

  int n_vec = 0;
  int n_bad = 0;

  // Upstream FIFO contents and the reference model of what the controller holds.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] m_buf[$];
  logic [DW-1:0] m_infl_word;
  bit            m_run, m_err, m_infl, m_zero;
  int unsigned   m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(bit p, bit rst, bit rdy, bit err, bit r, bit vld, int d, bit e);
    vec_t x;
    x.preload = p; x.rst = rst; x.rdy = rdy; x.err = err;
    x.e_read = r; x.e_valid = vld; x.e_data = DW'(d); x.e_err = e;
    return x;
  endfunction

  task automatic preload8();
    fq.delete();
    for (int k = 1; k <= 8; k++) fq.push_back(DW'(k));
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: compare against the model, then advance model and FIFO emulation.
  task automatic tick();
    bit e_read, e_valid, e_pop, a_read;
    int pend;
    #1;
    e_valid = (m_buf.size() > 0);
    e_pop   = e_valid && (out_ready === 1'b1);
    pend    = m_buf.size() + int'(m_infl) - int'(e_pop);
    e_read  = m_run && !m_err && (fq.size() > 0) && (pend < 2);
    chk("fifo_read", 32'(fifo_read), 32'(e_read));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("error_out", 32'(error_out), 32'(m_err));
    if (e_valid) chk("out_data", 32'(out_data), 32'(m_buf[0]));
    else if (m_zero) chk("out_data_rst", 32'(out_data), 32'(0));
`ifdef FIFO_POP_CNT_EN
    chk("word_count", 32'(word_count), m_cnt & 32'hFFFF);
`endif
    a_read = (fifo_read === 1'b1);
    @(posedge clk);
    #1;
    if (reset) begin
      m_run = 0; m_err = 0; m_infl = 0; m_zero = 1; m_cnt = 0;
      m_buf.delete();
    end else begin
      if (e_pop) begin
        void'(m_buf.pop_front());
        m_cnt = (m_cnt + 1) & 32'hFFFF;
      end
      if (m_infl) begin
        m_buf.push_back(m_infl_word);
        m_zero = 0;
      end
      m_infl = 0;
      if (fifo_error) m_err = 1;
      m_run = 1;
    end
    if (a_read && fq.size() > 0) begin
      fifo_data_out = fq.pop_front();
      if (!reset) begin
        m_infl      = 1;
        m_infl_word = fifo_data_out;
      end
    end
    fifo_empty = (fq.size() == 0);
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    int unsigned seq;

    reset = 1'b1; out_ready = 1'b0; fifo_error = 1'b0; fifo_empty = 1'b1; fifo_data_out = '0;
    m_run = 0; m_err = 0; m_infl = 0; m_zero = 1; m_cnt = 0; m_infl_word = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held with random inputs: everything stays quiet.
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) fq.push_back(DW'($urandom));
      fifo_empty    = (fq.size() == 0);
      fifo_error    = 1'($urandom);
      out_ready     = 1'($urandom);
      fifo_data_out = DW'($urandom);
      tick();
    end
    fq.delete(); fifo_empty = 1'b1; fifo_error = 1'b0;

    // Full-rate drain of 8 words, then backpressure with 8 words.
    tbl.push_back(v(1,1,1,0, 0,0,0,0));
    tbl.push_back(v(0,0,1,0, 0,0,0,0));
    tbl.push_back(v(0,0,1,0, 1,0,0,0));
    tbl.push_back(v(0,0,1,0, 1,0,0,0));
    for (int w = 1; w <= 6; w++) tbl.push_back(v(0,0,1,0, 1,1,w,0));
    tbl.push_back(v(0,0,1,0, 0,1,7,0));
    tbl.push_back(v(0,0,1,0, 0,1,8,0));
    tbl.push_back(v(0,0,1,0, 0,0,0,0));
    tbl.push_back(v(0,1,0,0, 0,0,0,0));
    tbl.push_back(v(1,1,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0));
    tbl.push_back(v(0,0,0,0, 1,0,0,0));
    tbl.push_back(v(0,0,0,0, 1,0,0,0));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0,0,0,0, 0,1,1,0));
    for (int w = 1; w <= 6; w++) tbl.push_back(v(0,0,1,0, 1,1,w,0));
    tbl.push_back(v(0,0,1,0, 0,1,7,0));
    tbl.push_back(v(0,0,1,0, 0,1,8,0));
    tbl.push_back(v(0,0,1,0, 0,0,0,0));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; out_ready = tbl[i].rdy; fifo_error = tbl[i].err;
      if (tbl[i].preload) preload8();
      #1;
      chk($sformatf("tbl%0d_read", i),  32'(fifo_read), 32'(tbl[i].e_read));
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_err", i),   32'(error_out), 32'(tbl[i].e_err));
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].e_data));
      tick();
    end

    // Error pulse with one word buffered and one in flight.
    reset = 1'b1; out_ready = 1'b0; fifo_error = 1'b0;
    tick();
    fq.delete();
    for (int k = 0; k < 4; k++) fq.push_back(DW'(10'h011 + k));
    fifo_empty = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    fifo_error = 1'b1;
    tick();
    fifo_error = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    chk("err_reads_stopped", 32'(fq.size()), 32'(2));
    #1;
    chk("err_sticky", 32'(error_out), 32'(1));
    chk("err_no_read", 32'(fifo_read), 32'(0));

    // Reset with two words buffered: they are discarded.
    reset = 1'b1; out_ready = 1'b0;
    tick();
    fq.delete();
    for (int k = 0; k < 6; k++) fq.push_back(DW'(10'h021 + k));
    fifo_empty = 1'b0;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (out_valid === 1'b1) begin
        seen = 1;
        chk("post_reset_word", 32'(out_data), 32'(10'h023));
      end
      tick();
    end
    chk("post_reset_seen", 32'(seen), 32'(1));

    // Random traffic against the reference model.
    seq = 32'h100;
    for (int i = 0; i < 800; i++) begin
      if (m_err && $urandom_range(0, 7) == 0) reset = 1'b1;
      else reset = ($urandom_range(0, 99) == 0);
      fifo_error = ($urandom_range(0, 149) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      if (fq.size() < 8 && $urandom_range(0, 1) == 1) begin
        fq.push_back(DW'(seq));
        seq = seq + 1;
      end
      fifo_empty = (fq.size() == 0);
      tick();
    end

`ifdef FIFO_POP_CNT_EN
    // Counter: 20 transfers, then run it up to the wrap.
    reset = 1'b1; fifo_error = 1'b0; out_ready = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 60 && m_cnt < 20; i++) begin
      if (fq.size() < 4) fq.push_back(DW'($urandom));
      fifo_empty = (fq.size() == 0);
      tick();
    end
    #1;
    chk("word_count_20", 32'(word_count), 32'(20));
    for (int i = 0; i < 70000 && m_cnt != 32'hFFFF; i++) begin
      if (fq.size() < 4) fq.push_back(DW'($urandom));
      fifo_empty = (fq.size() == 0);
      tick();
    end
    #1;
    chk("word_count_max", 32'(word_count), 32'hFFFF);
    for (int i = 0; i < 10 && m_cnt == 32'hFFFF; i++) begin
      if (fq.size() < 4) fq.push_back(DW'($urandom));
      fifo_empty = (fq.size() == 0);
      tick();
    end
    #1;
    chk("word_count_wrap", 32'(word_count), 32'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
